// File: rtl/depth_scan_controller.sv
// ---------------------------------------------------------------------------
// depth_scan_controller
//
// Address sequencer for one convolution layer. A read sweep walks
// row x col x filter-group addresses (with a configurable stride) towards the
// activation engine. A write sweep, driven by returning activations, walks
// the output row x col x filter-group space one column at a time.
//
// Optional feature (compile-time macro DEPTH_SE_TRIGGER_EN):
//   defined   -> SE_Start pulses the cycle after the write that completes
//                filter group SE_EN.
//   undefined -> SE_Start is tied to 0 and SE_EN is ignored.
//
// Ports
//   clk                     clock, all state on rising edge
//   RST                     asynchronous active-low reset
//   Start                   one-cycle scan request, honoured only in IDLE
//   R_Start / W_Start       first row/col index of read / write sweep (0..2)
//   R_Final_Row/W_Final_Row last legal read / write row & col index
//   Stride                  read step (0 behaves as 1)
//   Final_Filter            last filter-group index (read and write)
//   SE_EN                   write filter group that fires SE_Start
//   Rd_Ready                downstream accepts current read address
//   Act_Valid               activation available for write this cycle
//   R_Row/Col/Filter_Counter  current read address
//   W_Row/Col/Filter_Counter  current write address
//   R_Valid                 read address valid (READ state)
//   R_Depth_Done            pulse after the last read handshake
//   W_Depth_Done            pulse after the last write
//   SE_Start                pulse after filter group SE_EN is written
//   Busy                    high whenever not IDLE
// ---------------------------------------------------------------------------
module depth_scan_controller #(
  parameter int ROW_W = 7,
  parameter int FLT_W = 6
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             Start,
  input  logic [1:0]       R_Start,
  input  logic [1:0]       W_Start,
  input  logic [ROW_W-1:0] R_Final_Row,
  input  logic [ROW_W-1:0] W_Final_Row,
  input  logic [1:0]       Stride,
  input  logic [FLT_W-1:0] Final_Filter,
  input  logic [FLT_W-1:0] SE_EN,
  input  logic             Rd_Ready,
  input  logic             Act_Valid,
  output logic [ROW_W-1:0] R_Row_Counter,
  output logic [ROW_W-1:0] R_Col_Counter,
  output logic [FLT_W-1:0] R_Filter_Counter,
  output logic [FLT_W-1:0] W_Filter_Counter,
  output logic [ROW_W-1:0] W_Row_Counter,
  output logic [ROW_W-1:0] W_Col_Counter,
  output logic             R_Valid,
  output logic             R_Depth_Done,
  output logic             W_Depth_Done,
  output logic             SE_Start,
  output logic             Busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [ROW_W-1:0] r_rrow, r_rcol, r_wrow, r_wcol;
  logic [FLT_W-1:0] r_rflt, r_wflt;
  logic             r_wfrozen;
  logic             r_rdone, r_wdone;

  // ---------------------------------------------------------------- read side
  logic [ROW_W-1:0] w_rstart, w_wstart;
  logic [ROW_W:0]   w_step, w_rfinal, w_rcol_sum, w_rrow_sum;
  logic             w_rcol_wrap, w_rrow_wrap;
  logic             w_start_scan, w_rd_hs, w_rlast;

  assign w_rstart = {{(ROW_W-2){1'b0}}, R_Start};
  assign w_wstart = {{(ROW_W-2){1'b0}}, W_Start};

  // Extra MSB keeps the bound compare honest when final index is near 2^ROW_W-1.
  assign w_step     = {{(ROW_W-1){1'b0}}, ((Stride == 2'd0) ? 2'd1 : Stride)};
  assign w_rfinal   = {1'b0, R_Final_Row};
  assign w_rcol_sum = {1'b0, r_rcol} + w_step;
  assign w_rrow_sum = {1'b0, r_rrow} + w_step;
  assign w_rcol_wrap = (w_rcol_sum > w_rfinal);
  assign w_rrow_wrap = (w_rrow_sum > w_rfinal);

  assign w_start_scan = (r_state == IDLE) && Start;
  assign w_rd_hs      = (r_state == READ) && Rd_Ready;
  assign w_rlast      = w_rd_hs && w_rcol_wrap && w_rrow_wrap &&
                        (r_rflt == Final_Filter);

  // --------------------------------------------------------------- write side
  logic w_wr_en, w_wcol_wrap, w_wrow_wrap, w_wlast;

  // After the final write the counters park on the last address; stray
  // Act_Valid beats are dropped until the next Start.
  assign w_wr_en     = Act_Valid && !r_wfrozen &&
                       ((r_state == READ) || (r_state == DRAIN));
  // >= (not ==) so a bound below the start index still wraps on first beat.
  assign w_wcol_wrap = (r_wcol >= W_Final_Row);
  assign w_wrow_wrap = (r_wrow >= W_Final_Row);
  assign w_wlast     = w_wr_en && w_wcol_wrap && w_wrow_wrap &&
                       (r_wflt == Final_Filter);

  // ---------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (Start) w_state_nxt = READ;
      // Writes already complete (or completing now) -> no drain wait.
      READ:  if (w_rlast) w_state_nxt = (r_wfrozen || w_wlast) ? IDLE : DRAIN;
      DRAIN: if (w_wlast) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ----------------------------------------------------------- read counters
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_rrow <= '0;
      r_rcol <= '0;
      r_rflt <= '0;
    end else if (w_start_scan) begin
      r_rrow <= w_rstart;
      r_rcol <= w_rstart;
      r_rflt <= '0;
    end else if (w_rd_hs && !w_rlast) begin
      if (w_rcol_wrap) begin
        r_rcol <= w_rstart;
        if (w_rrow_wrap) begin
          r_rrow <= w_rstart;
          r_rflt <= r_rflt + 1'b1;
        end else begin
          r_rrow <= w_rrow_sum[ROW_W-1:0];
        end
      end else begin
        r_rcol <= w_rcol_sum[ROW_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------- write counters
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_wrow    <= '0;
      r_wcol    <= '0;
      r_wflt    <= '0;
      r_wfrozen <= 1'b0;
    end else if (w_start_scan) begin
      r_wrow    <= w_wstart;
      r_wcol    <= w_wstart;
      r_wflt    <= '0;
      r_wfrozen <= 1'b0;
    end else if (w_wlast) begin
      r_wfrozen <= 1'b1;
    end else if (w_wr_en) begin
      if (w_wcol_wrap) begin
        r_wcol <= w_wstart;
        if (w_wrow_wrap) begin
          r_wrow <= w_wstart;
          r_wflt <= r_wflt + 1'b1;
        end else begin
          r_wrow <= r_wrow + 1'b1;
        end
      end else begin
        r_wcol <= r_wcol + 1'b1;
      end
    end
  end

  // ----------------------------------------------------------- done pulses
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_rdone <= 1'b0;
      r_wdone <= 1'b0;
    end else begin
      r_rdone <= w_rlast;
      r_wdone <= w_wlast;
    end
  end

`ifdef DEPTH_SE_TRIGGER_EN
  logic r_se;
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) r_se <= 1'b0;
    else      r_se <= w_wr_en && w_wcol_wrap && w_wrow_wrap && (r_wflt == SE_EN);
  end
  assign SE_Start = r_se;
`else
  logic w_unused_se;
  assign w_unused_se = ^SE_EN;
  assign SE_Start    = 1'b0;
`endif

  // ---------------------------------------------------------------- outputs
  assign R_Row_Counter    = r_rrow;
  assign R_Col_Counter    = r_rcol;
  assign R_Filter_Counter = r_rflt;
  assign W_Row_Counter    = r_wrow;
  assign W_Col_Counter    = r_wcol;
  assign W_Filter_Counter = r_wflt;
  assign R_Valid          = (r_state == READ);
  assign Busy             = (r_state != IDLE);
  assign R_Depth_Done     = r_rdone;
  assign W_Depth_Done     = r_wdone;

endmodule

// File: tb/tb_depth_scan_controller.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for depth_scan_controller (ROW_W=7, FLT_W=6).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_depth_scan_controller;

`ifdef DEPTH_SE_TRIGGER_EN
  localparam logic SE_ON = 1'b1;
`else
  localparam logic SE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       RST;
  logic       Start;
  logic [1:0] R_Start, W_Start, Stride;
  logic [6:0] R_Final_Row, W_Final_Row;
  logic [5:0] Final_Filter, SE_EN;
  logic       Rd_Ready, Act_Valid;
  logic [6:0] R_Row_Counter, R_Col_Counter, W_Row_Counter, W_Col_Counter;
  logic [5:0] R_Filter_Counter, W_Filter_Counter;
  logic       R_Valid, R_Depth_Done, W_Depth_Done, SE_Start, Busy;
  logic [44:0] all_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  depth_scan_controller #(.ROW_W(7), .FLT_W(6)) dut (
    .clk(clk), .RST(RST), .Start(Start),
    .R_Start(R_Start), .W_Start(W_Start),
    .R_Final_Row(R_Final_Row), .W_Final_Row(W_Final_Row),
    .Stride(Stride), .Final_Filter(Final_Filter), .SE_EN(SE_EN),
    .Rd_Ready(Rd_Ready), .Act_Valid(Act_Valid),
    .R_Row_Counter(R_Row_Counter), .R_Col_Counter(R_Col_Counter),
    .R_Filter_Counter(R_Filter_Counter), .W_Filter_Counter(W_Filter_Counter),
    .W_Row_Counter(W_Row_Counter), .W_Col_Counter(W_Col_Counter),
    .R_Valid(R_Valid), .R_Depth_Done(R_Depth_Done), .W_Depth_Done(W_Depth_Done),
    .SE_Start(SE_Start), .Busy(Busy)
  );

  assign all_out = {R_Row_Counter, R_Col_Counter, R_Filter_Counter, W_Filter_Counter,
                    W_Row_Counter, W_Col_Counter, R_Valid, R_Depth_Done,
                    W_Depth_Done, SE_Start, Busy};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Read config; write side set to one address per filter so the writes
  // finish early during READ.
  task automatic setup_rd(input logic [1:0] rs, input logic [6:0] rf,
                          input logic [1:0] st, input logic [5:0] ff);
    R_Start = rs; R_Final_Row = rf; Stride = st; Final_Filter = ff;
    W_Start = 2'd0; W_Final_Row = 7'd0; SE_EN = 6'd0;
    Rd_Ready = 1'b1; Act_Valid = 1'b1; Start = 1'b0;
  endtask

  task automatic start_scan;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b0; Start = 1'b0; R_Start = 2'd0; W_Start = 2'd0; Stride = 2'd1;
    R_Final_Row = 7'd3; W_Final_Row = 7'd3; Final_Filter = 6'd1; SE_EN = 6'd0;
    Rd_Ready = 1'b0; Act_Valid = 1'b0;
    #2;
    n_tests++;
    if (all_out !== 45'd0) begin
      n_fail++; $display("FAIL reset_outputs got %h exp 0", all_out);
    end
    repeat (2) @(posedge clk);
    #1 RST = 1'b1;
    tick();
  endtask

  task automatic test_idle_write;
    Act_Valid = 1'b1; W_Final_Row = 7'd3;
    repeat (3) tick();
    n_tests++;
    if ({W_Row_Counter, W_Col_Counter, W_Filter_Counter, Busy, W_Depth_Done} !== 22'd0) begin
      n_fail++;
      $display("FAIL idle_write got w=(%0d,%0d,%0d) busy=%b done=%b exp all 0",
               W_Row_Counter, W_Col_Counter, W_Filter_Counter, Busy, W_Depth_Done);
    end
    Act_Valid = 1'b0;
  endtask

  task automatic test_full_scan;
    logic [6:0] er, ec; logic [5:0] ef;
    setup_rd(2'd0, 7'd3, 2'd1, 6'd1);
    start_scan();
    for (int i = 0; i < 32; i++) begin
      er = 7'((i / 4) % 4); ec = 7'(i % 4); ef = 6'(i / 16);
      n_tests++;
      if ({R_Row_Counter, R_Col_Counter, R_Filter_Counter} !== {er, ec, ef} ||
          {R_Valid, R_Depth_Done, Busy} !== 3'b101) begin
        n_fail++;
        $display("FAIL full_addr i=%0d got (%0d,%0d,%0d) v/d/b=%b%b%b exp (%0d,%0d,%0d) 101",
                 i, R_Row_Counter, R_Col_Counter, R_Filter_Counter,
                 R_Valid, R_Depth_Done, Busy, er, ec, ef);
      end
      n_tests++;
      if (W_Depth_Done !== (i == 2)) begin
        n_fail++; $display("FAIL full_wdone i=%0d got %b exp %b", i, W_Depth_Done, (i == 2));
      end
      tick();
    end
    n_tests++;
    if ({R_Depth_Done, Busy, R_Valid} !== 3'b100 ||
        {W_Row_Counter, W_Col_Counter, W_Filter_Counter} !== {7'd0, 7'd0, 6'd1}) begin
      n_fail++;
      $display("FAIL full_end got d/b/v=%b%b%b w=(%0d,%0d,%0d) exp 100 w=(0,0,1)",
               R_Depth_Done, Busy, R_Valid, W_Row_Counter, W_Col_Counter, W_Filter_Counter);
    end
    tick();
    n_tests++;
    if (R_Depth_Done !== 1'b0) begin
      n_fail++; $display("FAIL full_pulse_len got %b exp 0", R_Depth_Done);
    end
  endtask

  task automatic test_stride;
    logic [6:0] er, ec; logic [5:0] ef;
    setup_rd(2'd1, 7'd4, 2'd2, 6'd1);
    start_scan();
    for (int i = 0; i < 8; i++) begin
      er = ((i % 4) < 2) ? 7'd1 : 7'd3;
      ec = (i % 2 == 1) ? 7'd3 : 7'd1;
      ef = 6'(i / 4);
      n_tests++;
      if ({R_Row_Counter, R_Col_Counter, R_Filter_Counter, R_Valid} !== {er, ec, ef, 1'b1}) begin
        n_fail++;
        $display("FAIL stride_addr i=%0d got (%0d,%0d,%0d) v=%b exp (%0d,%0d,%0d) v=1",
                 i, R_Row_Counter, R_Col_Counter, R_Filter_Counter, R_Valid, er, ec, ef);
      end
      tick();
    end
    n_tests++;
    if ({R_Depth_Done, Busy} !== 2'b10) begin
      n_fail++; $display("FAIL stride_done got d/b=%b%b exp 10", R_Depth_Done, Busy);
    end
  endtask

  task automatic test_ready_toggle;
    int k;
    setup_rd(2'd0, 7'd1, 2'd0, 6'd0);  // Stride 0 behaves as 1
    start_scan();
    k = 0;
    for (int j = 0; j < 12 && k < 4; j++) begin
      n_tests++;
      if ({R_Row_Counter, R_Col_Counter, R_Filter_Counter} !==
          {7'(k / 2), 7'(k % 2), 6'd0}) begin
        n_fail++;
        $display("FAIL ready_addr j=%0d got (%0d,%0d,%0d) exp (%0d,%0d,0)",
                 j, R_Row_Counter, R_Col_Counter, R_Filter_Counter, k / 2, k % 2);
      end
      Rd_Ready = (j % 2 == 0);
      tick();
      if (Rd_Ready) k++;
    end
    Rd_Ready = 1'b1;
    n_tests++;
    if (k != 4 || {R_Depth_Done, Busy} !== 2'b10) begin
      n_fail++; $display("FAIL ready_done got k=%0d d/b=%b%b exp k=4 10", k, R_Depth_Done, Busy);
    end
  endtask

  task automatic test_bound_below;
    setup_rd(2'd1, 7'd0, 2'd1, 6'd1);
    start_scan();
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if ({R_Row_Counter, R_Col_Counter, R_Filter_Counter} !== {7'd1, 7'd1, 6'(i)}) begin
        n_fail++;
        $display("FAIL below_addr i=%0d got (%0d,%0d,%0d) exp (1,1,%0d)",
                 i, R_Row_Counter, R_Col_Counter, R_Filter_Counter, i);
      end
      tick();
    end
    // last read and last write land on the same edge
    n_tests++;
    if ({R_Depth_Done, W_Depth_Done, Busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL below_done got rd/wd/b=%b%b%b exp 110", R_Depth_Done, W_Depth_Done, Busy);
    end
  endtask

  task automatic test_se_drain;
    logic [6:0] er, ec; logic [5:0] ef; logic es;
    setup_rd(2'd0, 7'd0, 2'd1, 6'd2);
    W_Final_Row = 7'd1; SE_EN = 6'd1; Act_Valid = 1'b0;
    start_scan();
    repeat (3) tick();
    n_tests++;
    if ({R_Valid, Busy, R_Depth_Done} !== 3'b011) begin
      n_fail++; $display("FAIL drain_enter got v/b/d=%b%b%b exp 011", R_Valid, Busy, R_Depth_Done);
    end
    Act_Valid = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n < 12) begin
        ec = 7'(n % 2); er = 7'((n / 2) % 2); ef = 6'(n / 4);
      end else begin
        ec = 7'd1; er = 7'd1; ef = 6'd2;
      end
      es = SE_ON && (n == 8);
      n_tests++;
      if ({W_Row_Counter, W_Col_Counter, W_Filter_Counter} !== {er, ec, ef} ||
          {SE_Start, W_Depth_Done, Busy} !== {es, (n == 12), (n != 12)}) begin
        n_fail++;
        $display("FAIL se_write n=%0d got (%0d,%0d,%0d) se/wd/b=%b%b%b exp (%0d,%0d,%0d) %b%b%b",
                 n, W_Row_Counter, W_Col_Counter, W_Filter_Counter, SE_Start, W_Depth_Done,
                 Busy, er, ec, ef, es, (n == 12), (n != 12));
      end
    end
    Act_Valid = 1'b0;
    tick();
    n_tests++;
    if ({SE_Start, W_Depth_Done, Busy} !== 3'b000) begin
      n_fail++; $display("FAIL se_after got %b%b%b exp 000", SE_Start, W_Depth_Done, Busy);
    end
  endtask

  task automatic test_reset_mid;
    setup_rd(2'd0, 7'd3, 2'd1, 6'd1);
    Act_Valid = 1'b0;
    start_scan();
    repeat (4) tick();
    n_tests++;
    if ({R_Row_Counter, R_Col_Counter} !== {7'd1, 7'd0}) begin
      n_fail++; $display("FAIL mid_pre got (%0d,%0d) exp (1,0)", R_Row_Counter, R_Col_Counter);
    end
    RST = 1'b0;
    #1;
    n_tests++;
    if (all_out !== 45'd0) begin
      n_fail++; $display("FAIL mid_async got %h exp 0", all_out);
    end
    tick();
    n_tests++;
    if (all_out !== 45'd0) begin
      n_fail++; $display("FAIL mid_hold got %h exp 0", all_out);
    end
    RST = 1'b1;
    setup_rd(2'd2, 7'd3, 2'd1, 6'd0);
    tick();
    start_scan();
    n_tests++;
    if ({R_Row_Counter, R_Col_Counter, R_Filter_Counter, R_Valid} !== {7'd2, 7'd2, 6'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_restart got (%0d,%0d,%0d) v=%b exp (2,2,0) v=1",
               R_Row_Counter, R_Col_Counter, R_Filter_Counter, R_Valid);
    end
    repeat (3) tick();
    n_tests++;
    if ({R_Row_Counter, R_Col_Counter} !== {7'd3, 7'd3}) begin
      n_fail++; $display("FAIL mid_last got (%0d,%0d) exp (3,3)", R_Row_Counter, R_Col_Counter);
    end
    tick();
    n_tests++;
    if ({R_Depth_Done, Busy} !== 2'b10) begin
      n_fail++; $display("FAIL mid_done got d/b=%b%b exp 10", R_Depth_Done, Busy);
    end
  endtask

  task automatic test_start_held;
    setup_rd(2'd0, 7'd1, 2'd1, 6'd0);
    Start = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({R_Row_Counter, R_Col_Counter, R_Filter_Counter, Busy} !==
          {7'(i / 2), 7'(i % 2), 6'd0, 1'b1}) begin
        n_fail++;
        $display("FAIL held_addr i=%0d got (%0d,%0d,%0d) b=%b exp (%0d,%0d,0) b=1",
                 i, R_Row_Counter, R_Col_Counter, R_Filter_Counter, Busy, i / 2, i % 2);
      end
      if (i == 3) Start = 1'b0;
      tick();
    end
    n_tests++;
    if ({R_Depth_Done, Busy} !== 2'b10) begin
      n_fail++; $display("FAIL held_done got d/b=%b%b exp 10", R_Depth_Done, Busy);
    end
    tick();
    n_tests++;
    if ({R_Depth_Done, Busy} !== 2'b00) begin
      n_fail++; $display("FAIL held_idle got d/b=%b%b exp 00", R_Depth_Done, Busy);
    end
  endtask

  initial begin
    test_reset();
    test_idle_write();
    test_full_scan();
    test_stride();
    test_ready_toggle();
    test_bound_below();
    test_se_drain();
    test_reset_mid();
    test_start_held();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/depth_scan_controller.md
DEPTH_SCAN_CONTROLLER -- requirements
Module: depth_scan_controller

Interface
REQ-001 Parameter ROW_W, default 7; width of all row/col counters and bounds (max index 2^ROW_W-1).
REQ-002 Parameter FLT_W, default 6; width of filter counters, Final_Filter and SE_EN.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  one-cycle request to begin a layer scan; sampled only in IDLE.
REQ-006 R_Start, W_Start  input  2 each  first row/col index of the read and write sweeps (0..2).
REQ-007 R_Final_Row, W_Final_Row  input  ROW_W each  last legal read/write index, applied to both rows and cols.
REQ-008 Stride  input  2  read step; value 0 is treated as 1.
REQ-009 Final_Filter  input  FLT_W  last filter-group index.
REQ-010 SE_EN  input  FLT_W  write filter index whose completion triggers SE_Start.
REQ-011 Rd_Ready  input  1  downstream accepts the current read address.
REQ-012 Act_Valid  input  1  activation result available for writing this cycle.
REQ-013 R_Row_Counter, R_Col_Counter  output  ROW_W each  current read address.
REQ-014 R_Filter_Counter, W_Filter_Counter  output  FLT_W each  current read/write filter group.
REQ-015 W_Row_Counter, W_Col_Counter  output  ROW_W each  current write address.
REQ-016 R_Valid  output  1  read address valid.
REQ-017 R_Depth_Done, W_Depth_Done, SE_Start  output  1 each  registered one-cycle pulses.
REQ-018 Busy  output  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, READ, DRAIN; IDLE->READ on Start, READ->DRAIN after the last read handshake, DRAIN->IDLE after the last write.
REQ-020 On IDLE->READ, read and write row/col SHALL load R_Start/W_Start and both filter counters SHALL load 0.
REQ-021 R_Valid SHALL be 1 exactly in READ; read counters SHALL advance only on R_Valid & Rd_Ready, otherwise hold.
REQ-022 Read col step: if R_Col+Stride_eff > R_Final_Row (compared at ROW_W+1 bits), col SHALL wrap to R_Start and row SHALL step by Stride_eff, else col SHALL add Stride_eff.
REQ-023 Row wrap uses the same rule as col; on row wrap, row SHALL return to R_Start and R_Filter_Counter SHALL increment.
REQ-024 Handshake with row and col wrapping and R_Filter_Counter==Final_Filter SHALL be the last read; R_Depth_Done pulses the following cycle.
REQ-025 Write counters SHALL advance by 1 col per Act_Valid cycle in READ or DRAIN, wrapping col/row/filter at W_Final_Row/W_Final_Row/Final_Filter.
REQ-026 Act_Valid in IDLE SHALL be ignored; counters hold.
REQ-027 The last write (col==row==W_Final_Row, filter==Final_Filter) SHALL pulse W_Depth_Done next cycle.
REQ-028 Last write in READ (read not yet complete) SHALL freeze write counters at final values, ignore further Act_Valid, and move READ->IDLE directly after the last read, suppressing the DRAIN wait.
REQ-029 Start while Busy SHALL be ignored.
REQ-030 Final bound below start index (e.g. R_Final_Row=0, R_Start=1) SHALL produce a single address per filter at the start index.

Reset
REQ-031 RST low SHALL force IDLE; all counters 0; R_Valid, Busy, R_Depth_Done, W_Depth_Done, SE_Start 0.
REQ-032 Reset mid-scan SHALL abort immediately; no done pulse issued.

Configuration
REQ-033 Macro DEPTH_SE_TRIGGER_EN defined: SE_Start SHALL pulse the cycle after the write that completes filter group SE_EN (row/col at W_Final_Row).
REQ-034 Macro undefined: SE_Start SHALL be constant 0 and SE_EN SHALL be unused; all other behaviour identical.

Verification
REQ-035 Start, R_Start=0, R_Final_Row=3, Stride=1, Final_Filter=1, Rd_Ready=1 -> 32 read addresses, (0,0)..(3,3) x2; R_Depth_Done one pulse after 32nd handshake.
REQ-036 Stride=2, R_Start=1, R_Final_Row=4 -> reads (1,1),(1,3),(3,1),(3,3) per filter; no index exceeds 4.
REQ-037 Rd_Ready toggled 1,0,1,0 -> counters change only on Ready cycles; address held while Ready=0.
REQ-038 W_Final_Row=1, Final_Filter=2, SE_EN=1, Act_Valid=1 for 12 cycles -> SE_Start after 8th write (macro on; 0 with macro off); W_Depth_Done after 12th; Busy falls.
REQ-039 RST low at mid-scan -> all outputs 0 next edge; Start afterwards begins a fresh scan from R_Start.
REQ-040 Start held high during READ -> no counter reload; scan completes normally.
